// File: rtl/wisc_pkg.sv
// Shared fetch-unit definitions: state encoding, bubble word, exception vector
// and PC increment helper.
package wisc_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [PC_W-1:0] EXCP_VEC  = 16'h0002;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_WAIT   = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_t;

  // Instructions are 2 bytes; the PC wraps FFFE -> 0000.
  function automatic logic [PC_W-1:0] pc_plus2(input logic [PC_W-1:0] pc);
    return pc + 16'h0002;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: 16-bit register with load enable and synchronous reset.
module pc_reg
  import wisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  // PC update: reset value, load, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with wait/stall handling, redirects and halt.
// Define FETCH_EXCP_EN to enable excp/rti handling and the epc register.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] EXCP_VEC  = wisc_pkg::EXCP_VEC,
  parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        excp,
  input  logic        rti,
  input  logic [15:0] excp_pc,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic [15:0] epc
);

  fetch_state_t state, state_nxt;
  logic [15:0]  pc, pc_nxt;
  logic         pc_load;
  logic [15:0]  instr_nxt, pc2_nxt;
  logic         valid_nxt;
  logic         hold_valid, hold_valid_nxt;
  logic [15:0]  hold_data, hold_data_nxt;
  logic         fetch_req;
  logic         deliver;
  logic [15:0]  deliver_data;
  logic         excp_act, rti_act;
  logic [15:0]  epc_q;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_nxt),
    .q    (pc)
  );

`ifdef FETCH_EXCP_EN
  assign excp_act = excp;
  assign rti_act  = rti;

  // Exception return PC, frozen while halted
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= 16'h0000;
    end else if (excp_act && (state != ST_HALTED)) begin
      epc_q <= excp_pc;
    end else begin
      epc_q <= epc_q;
    end
  end
`else
  logic unused_excp;
  assign unused_excp = ^{excp, rti, excp_pc};
  assign excp_act    = 1'b0;
  assign rti_act     = 1'b0;
  assign epc_q       = 16'h0000;
`endif

  assign epc       = epc_q;
  assign imem_addr = pc;
  assign imem_en   = fetch_req & ~rst;

  // Next-state, fetch request and pipeline-register selection
  always_comb begin
    state_nxt      = state;
    pc_load        = 1'b0;
    pc_nxt         = pc;
    instr_nxt      = if_instr;
    pc2_nxt        = if_pc2;
    valid_nxt      = if_valid;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    fetch_req      = 1'b0;
    deliver        = 1'b0;
    deliver_data   = imem_data;

    if (state == ST_HALTED) begin
      state_nxt = ST_HALTED;
    end else if (excp_act || rti_act || redirect) begin
      // Squash: anything in flight or held is dropped, even if done this cycle
      pc_load = 1'b1;
      if (excp_act) begin
        pc_nxt = EXCP_VEC;
      end else if (rti_act) begin
        pc_nxt = epc_q;
      end else begin
        pc_nxt = redirect_pc;
      end
      state_nxt      = ST_RUN;
      instr_nxt      = NOP_INSTR;
      valid_nxt      = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (halt) begin
      state_nxt      = ST_HALTED;
      instr_nxt      = NOP_INSTR;
      valid_nxt      = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (hold_valid) begin
      if (stall) begin
        hold_valid_nxt = 1'b1;
      end else begin
        deliver        = 1'b1;
        deliver_data   = hold_data;
        hold_valid_nxt = 1'b0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (stall) begin
            state_nxt = ST_RUN;
          end else begin
            fetch_req = 1'b1;
            if (imem_done) begin
              deliver = 1'b1;
            end else begin
              state_nxt = ST_WAIT;
              instr_nxt = NOP_INSTR;
              valid_nxt = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          // The outstanding request stays asserted through a stall
          fetch_req = 1'b1;
          if (imem_done) begin
            state_nxt = ST_RUN;
            if (stall) begin
              hold_valid_nxt = 1'b1;
              hold_data_nxt  = imem_data;
            end else begin
              deliver = 1'b1;
            end
          end else begin
            state_nxt = ST_WAIT;
            if (stall) begin
              valid_nxt = if_valid;
            end else begin
              instr_nxt = NOP_INSTR;
              valid_nxt = 1'b0;
            end
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end

    if (deliver) begin
      instr_nxt = deliver_data;
      pc2_nxt   = pc_plus2(pc);
      valid_nxt = 1'b1;
      pc_load   = 1'b1;
      pc_nxt    = pc_plus2(pc);
    end else begin
      deliver_data = imem_data;
    end
  end

  // State and fetch pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      if_instr   <= NOP_INSTR;
      if_pc2     <= 16'h0000;
      if_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 16'h0000;
    end else begin
      state      <= state_nxt;
      if_instr   <= instr_nxt;
      if_pc2     <= pc2_nxt;
      if_valid   <= valid_nxt;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory word = addr ^ 16'h5A00.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt, excp, rti, imem_done;
  logic [15:0] redirect_pc, excp_pc;
  logic [15:0] imem_addr, imem_data, if_instr, if_pc2, epc;
  logic        imem_en, if_valid;
  int          total = 0;
  int          bad = 0;

  assign imem_data = imem_addr ^ 16'h5A00;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .excp(excp), .rti(rti), .excp_pc(excp_pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_done(imem_done), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc2(if_pc2), .if_valid(if_valid), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0; excp = 1'b0; rti = 1'b0;
    imem_done = 1'b0; redirect_pc = 16'h0000; excp_pc = 16'h0000;
    step();
    chk("rst_instr", if_instr, 16'h0800);
    chk("rst_valid", if_valid, 16'h0000);
    chk("rst_pc2", if_pc2, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    #1 chk("rst_en", imem_en, 16'h0000);

    // Back-to-back fetches
    rst = 1'b0; imem_done = 1'b1;
    #1 chk("seq_en0", imem_en, 16'h0001);
    chk("seq_addr0", imem_addr, 16'h0000);
    step();
    chk("seq_instr0", if_instr, 16'h5A00);
    chk("seq_pc2_0", if_pc2, 16'h0002);
    chk("seq_valid0", if_valid, 16'h0001);
    chk("seq_addr1", imem_addr, 16'h0002);
    step();
    chk("seq_instr1", if_instr, 16'h5A02);
    chk("seq_pc2_1", if_pc2, 16'h0004);
    chk("seq_addr2", imem_addr, 16'h0004);

    // Three wait cycles at 0004
    imem_done = 1'b0;
    step();
    chk("wait_bub1_valid", if_valid, 16'h0000);
    chk("wait_bub1_instr", if_instr, 16'h0800);
    #1 chk("wait_en", imem_en, 16'h0001);
    chk("wait_addr", imem_addr, 16'h0004);
    step();
    chk("wait_bub2_valid", if_valid, 16'h0000);
    step();
    chk("wait_bub3_valid", if_valid, 16'h0000);
    chk("wait_bub3_addr", imem_addr, 16'h0004);
    imem_done = 1'b1;
    step();
    chk("wait_instr", if_instr, 16'h5A04);
    chk("wait_pc2", if_pc2, 16'h0006);
    chk("wait_valid", if_valid, 16'h0001);
    step();
    chk("seq_instr3", if_instr, 16'h5A06);
    chk("seq_addr4", imem_addr, 16'h0008);

    // Redirect while the 0008 fetch completes
    imem_done = 1'b0;
    step();
    chk("redir_pre_valid", if_valid, 16'h0000);
    imem_done = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    #1 chk("redir_en", imem_en, 16'h0000);
    step();
    redirect = 1'b0;
    chk("redir_valid", if_valid, 16'h0000);
    chk("redir_instr", if_instr, 16'h0800);
    chk("redir_addr", imem_addr, 16'h0100);
    #1 chk("redir_en_after", imem_en, 16'h0001);
    step();
    chk("redir_fetch", if_instr, 16'h5B00);
    chk("redir_pc2", if_pc2, 16'h0102);

    // Stall for two cycles with a fetch outstanding at 0102
    imem_done = 1'b0;
    step();
    chk("stall_pre_valid", if_valid, 16'h0000);
    stall = 1'b1; imem_done = 1'b1;
    #1 chk("stall_wait_en", imem_en, 16'h0001);
    step();
    imem_done = 1'b0;
    chk("stall_hold_valid1", if_valid, 16'h0000);
    chk("stall_hold_instr1", if_instr, 16'h0800);
    chk("stall_addr", imem_addr, 16'h0102);
    #1 chk("stall_en1", imem_en, 16'h0000);
    step();
    chk("stall_hold_valid2", if_valid, 16'h0000);
    stall = 1'b0;
    #1 chk("unstall_en", imem_en, 16'h0000);
    step();
    chk("unstall_instr", if_instr, 16'h5B02);
    chk("unstall_pc2", if_pc2, 16'h0104);
    chk("unstall_valid", if_valid, 16'h0001);
    chk("unstall_addr", imem_addr, 16'h0104);

    // Stall in RUN with no request outstanding
    stall = 1'b1; imem_done = 1'b1;
    #1 chk("run_stall_en", imem_en, 16'h0000);
    step();
    chk("run_stall_instr", if_instr, 16'h5B02);
    chk("run_stall_valid", if_valid, 16'h0001);
    chk("run_stall_addr", imem_addr, 16'h0104);
    stall = 1'b0;

    // Exception then return
    excp = 1'b1; excp_pc = 16'h0032;
`ifdef FETCH_EXCP_EN
    #1 chk("excp_en", imem_en, 16'h0000);
    step();
    excp = 1'b0;
    chk("excp_epc", epc, 16'h0032);
    chk("excp_valid", if_valid, 16'h0000);
    chk("excp_addr", imem_addr, 16'h0002);
    step();
    chk("excp_fetch", if_instr, 16'h5A02);
    chk("excp_pc2", if_pc2, 16'h0004);
    rti = 1'b1;
    #1 chk("rti_en", imem_en, 16'h0000);
    step();
    rti = 1'b0;
    chk("rti_valid", if_valid, 16'h0000);
    chk("rti_addr", imem_addr, 16'h0032);
    step();
    chk("rti_fetch", if_instr, 16'h5A32);
    chk("rti_pc2", if_pc2, 16'h0034);
`else
    #1 chk("excp_ign_en", imem_en, 16'h0001);
    step();
    excp = 1'b0;
    chk("excp_ign_epc", epc, 16'h0000);
    chk("excp_ign_instr", if_instr, 16'h5B04);
    chk("excp_ign_addr", imem_addr, 16'h0106);
    step();
    chk("excp_ign_instr2", if_instr, 16'h5B06);
    rti = 1'b1;
    #1 chk("rti_ign_en", imem_en, 16'h0001);
    step();
    rti = 1'b0;
    chk("rti_ign_instr", if_instr, 16'h5B08);
    chk("rti_ign_addr", imem_addr, 16'h010A);
    chk("rti_ign_epc", epc, 16'h0000);
`endif

    // Halt: fetch stops and only reset recovers
    halt = 1'b1;
    #1 chk("halt_en", imem_en, 16'h0000);
    step();
    halt = 1'b0;
    chk("halt_valid", if_valid, 16'h0000);
    chk("halt_instr", if_instr, 16'h0800);
    #1 chk("halted_en1", imem_en, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0200;
    #1 chk("halted_redir_en", imem_en, 16'h0000);
    step();
    step();
    redirect = 1'b0;
    #1 chk("halted_en2", imem_en, 16'h0000);
    chk("halted_valid", if_valid, 16'h0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("rerst_addr", imem_addr, 16'h0000);
    chk("rerst_en", imem_en, 16'h0001);
    step();
    chk("rerst_instr", if_instr, 16'h5A00);
    chk("rerst_pc2", if_pc2, 16'h0002);

    // Reset in the middle of a wait drops the pending word
    imem_done = 1'b0;
    step();
    rst = 1'b1; imem_done = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait_valid", if_valid, 16'h0000);
    chk("rstwait_instr", if_instr, 16'h0800);
    chk("rstwait_addr", imem_addr, 16'h0000);
    step();
    chk("rstwait_fetch", if_instr, 16'h5A00);

    // PC+2 wraps at the top of the address space
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFE);
    step();
    chk("wrap_instr", if_instr, 16'hA5FE);
    chk("wrap_pc2", if_pc2, 16'h0000);
    chk("wrap_next_addr", imem_addr, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
